apb_protocol_monitor: RTL and testbench

//  Synthesizable passive APB4 bus monitor for the APB slave environment; generalises the assertion-only

---
 rtl/apb_mon_pkg.sv | 30 +++
 rtl/apb_sat_counter.sv | 24 ++
 rtl/apb_protocol_monitor.sv | 228 ++++++++++++++++++++++
 tb/tb_apb_protocol_monitor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mon_pkg.sv
// Shared types for the passive APB4 protocol monitor.
package apb_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam int NUM_ERR             = 7;
   localparam int ERR_MULTI_SEL       = 0;
   localparam int ERR_ENABLE_NO_SETUP = 1;
   localparam int ERR_SETUP_NO_ENABLE = 2;
   localparam int ERR_UNSTABLE        = 3;
   localparam int ERR_TIMEOUT         = 4;
   localparam int ERR_PSEL_DROP       = 5;
   localparam int ERR_STRB_ON_READ    = 6;

   typedef logic [2:0] err_code_t;

   function automatic err_code_t lowest_err(input logic [NUM_ERR-1:0] v);
      err_code_t c;
      c = '0;
      for (int i = NUM_ERR - 1; i >= 0; i--) begin
         if (v[i]) c = err_code_t'(i);
      end
      return c;
   endfunction

endpackage

// File: rtl/apb_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
module apb_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB4 protocol monitor: violation flags/codes and traffic counters.
// Define APB_MON_LATENCY_EN to add the max_wait output.
module apb_protocol_monitor
   import apb_mon_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int NUM_SLAVES     = 1,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic [NUM_SLAVES-1:0]   PSEL,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic                    PWRITE,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic                    PENABLE,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR,
   input  logic                    err_clear,
   output logic                    err_valid,
   output logic [2:0]              err_code,
   output logic [NUM_ERR-1:0]      err_flags,
   output logic                    xfer_done,
   output logic                    busy,
   output logic [CNT_WIDTH-1:0]    wr_cnt,
   output logic [CNT_WIDTH-1:0]    rd_cnt,
   output logic [CNT_WIDTH-1:0]    slverr_cnt
`ifdef APB_MON_LATENCY_EN
   ,
   output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] max_wait
`endif
);

   localparam int SW  = DATA_WIDTH / 8;
   localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);

   state_t                r_state;
   logic [WCW-1:0]        r_wait;
   logic [NUM_SLAVES-1:0] r_psel;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic                  r_pwrite;
   logic [SW-1:0]         r_pstrb;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  r_err_valid;
   err_code_t             r_err_code;
   logic [NUM_ERR-1:0]    r_err_flags;
   logic                  r_xfer_done;

   state_t                w_next;
   logic [WCW-1:0]        w_wait_nx;
   logic [WCW-1:0]        w_wait_inc;
   logic [NUM_ERR-1:0]    w_err;
   logic                  w_sel;
   logic                  w_setup;
   logic                  w_access;
   logic                  w_mismatch;
   logic                  w_cap;
   logic                  w_done;
   logic                  w_unused;

   assign w_sel      = |PSEL;
   assign w_setup    = w_sel & ~PENABLE;
   assign w_access   = w_sel & PENABLE;
   assign w_wait_inc = r_wait + 1'b1;
   assign w_unused   = ^PRDATA;

   assign w_mismatch = (PSEL   != r_psel)   | (PADDR  != r_paddr) |
                       (PWRITE != r_pwrite) | (PSTRB  != r_pstrb) |
                       (PWDATA != r_pwdata);

   always_comb begin
      w_next    = r_state;
      w_wait_nx = r_wait;
      w_err     = '0;
      w_cap     = 1'b0;
      w_done    = 1'b0;
      w_err[ERR_MULTI_SEL] = ($countones(PSEL) > 1);
      unique case (r_state)
         IDLE: begin
            w_wait_nx = '0;
            if (w_setup) begin
               w_next = SETUP;
               w_cap  = 1'b1;
               w_err[ERR_STRB_ON_READ] = ~PWRITE & (|PSTRB);
            end else begin
               w_next = IDLE;
               w_err[ERR_ENABLE_NO_SETUP] = w_access;
            end
         end
         SETUP: begin
            if (w_access) begin
               w_err[ERR_UNSTABLE] = w_mismatch;
               if (PREADY) begin
                  w_done    = 1'b1;
                  w_next    = IDLE;
                  w_wait_nx = '0;
               end else if (TIMEOUT_CYCLES == 1) begin
                  w_err[ERR_TIMEOUT] = 1'b1;
                  w_next    = IDLE;
                  w_wait_nx = '0;
               end else begin
                  w_next    = WAIT;
                  w_wait_nx = WCW'(1);
               end
            end else begin
               // Missing access phase: treat this cycle as a fresh IDLE sample.
               w_err[ERR_SETUP_NO_ENABLE] = 1'b1;
               w_wait_nx = '0;
               if (w_setup) begin
                  w_next = SETUP;
                  w_cap  = 1'b1;
                  w_err[ERR_STRB_ON_READ] = ~PWRITE & (|PSTRB);
               end else begin
                  w_next = IDLE;
               end
            end
         end
         WAIT: begin
            if (!w_access) begin
               w_err[ERR_PSEL_DROP] = 1'b1;
               w_next    = IDLE;
               w_wait_nx = '0;
            end else begin
               w_err[ERR_UNSTABLE] = w_mismatch;
               if (PREADY) begin
                  w_done    = 1'b1;
                  w_next    = IDLE;
                  w_wait_nx = '0;
               end else if (w_wait_inc == WCW'(TIMEOUT_CYCLES)) begin
                  w_err[ERR_TIMEOUT] = 1'b1;
                  w_next    = IDLE;
                  w_wait_nx = '0;
               end else begin
                  w_next    = WAIT;
                  w_wait_nx = w_wait_inc;
               end
            end
         end
         default: begin
            w_next    = IDLE;
            w_wait_nx = '0;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_state     <= IDLE;
         r_wait      <= '0;
         r_psel      <= '0;
         r_paddr     <= '0;
         r_pwrite    <= 1'b0;
         r_pstrb     <= '0;
         r_pwdata    <= '0;
         r_err_valid <= 1'b0;
         r_err_code  <= '0;
         r_err_flags <= '0;
         r_xfer_done <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_wait      <= w_wait_nx;
         r_err_valid <= |w_err;
         r_xfer_done <= w_done;
         r_err_flags <= (err_clear ? '0 : r_err_flags) | w_err;
         if (|w_err) r_err_code <= lowest_err(w_err);
         if (w_cap) begin
            r_psel   <= PSEL;
            r_paddr  <= PADDR;
            r_pwrite <= PWRITE;
            r_pstrb  <= PSTRB;
            r_pwdata <= PWDATA;
         end
      end
   end

   assign err_valid = r_err_valid;
   assign err_code  = r_err_code;
   assign err_flags = r_err_flags;
   assign xfer_done = r_xfer_done;
   assign busy      = (r_state != IDLE);

   apb_sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
      .i_clk   (PCLK),
      .i_rst_n (PRESETn),
      .i_clr   (1'b0),
      .i_inc   (w_done & r_pwrite),
      .o_cnt   (wr_cnt)
   );

   apb_sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
      .i_clk   (PCLK),
      .i_rst_n (PRESETn),
      .i_clr   (1'b0),
      .i_inc   (w_done & ~r_pwrite),
      .o_cnt   (rd_cnt)
   );

   apb_sat_counter #(.WIDTH(CNT_WIDTH)) u_slverr_cnt (
      .i_clk   (PCLK),
      .i_rst_n (PRESETn),
      .i_clr   (1'b0),
      .i_inc   (w_done & PSLVERR),
      .o_cnt   (slverr_cnt)
   );

`ifdef APB_MON_LATENCY_EN
   logic [WCW-1:0] r_max_wait;
   logic [WCW-1:0] w_done_wait;

   // A transfer finishing straight out of SETUP had no wait states.
   assign w_done_wait = (r_state == WAIT) ? r_wait : '0;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_max_wait <= '0;
      end else if (w_done && (w_done_wait > r_max_wait)) begin
         r_max_wait <= w_done_wait;
      end
   end

   assign max_wait = r_max_wait;
`endif

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed, table-driven bench for apb_protocol_monitor (NUM_SLAVES=2, CNT_WIDTH=4).
module tb_apb_protocol_monitor;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NS = 2;
   localparam int TO = 16;
   localparam int CW = 4;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic [NS-1:0] PSEL;
   logic [AW-1:0] PADDR;
   logic          PWRITE;
   logic [3:0]    PSTRB;
   logic [DW-1:0] PWDATA;
   logic          PENABLE;
   logic [DW-1:0] PRDATA;
   logic          PREADY;
   logic          PSLVERR;
   logic          err_clear;
   logic          err_valid;
   logic [2:0]    err_code;
   logic [6:0]    err_flags;
   logic          xfer_done;
   logic          busy;
   logic [CW-1:0] wr_cnt;
   logic [CW-1:0] rd_cnt;
   logic [CW-1:0] slverr_cnt;
`ifdef APB_MON_LATENCY_EN
   logic [4:0]    max_wait;
`endif

   int total = 0;
   int bad   = 0;

   always #5 PCLK = ~PCLK;

   apb_protocol_monitor #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .NUM_SLAVES     (NS),
      .TIMEOUT_CYCLES (TO),
      .CNT_WIDTH      (CW)
   ) dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .PSEL       (PSEL),
      .PADDR      (PADDR),
      .PWRITE     (PWRITE),
      .PSTRB      (PSTRB),
      .PWDATA     (PWDATA),
      .PENABLE    (PENABLE),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR),
      .err_clear  (err_clear),
      .err_valid  (err_valid),
      .err_code   (err_code),
      .err_flags  (err_flags),
      .xfer_done  (xfer_done),
      .busy       (busy),
      .wr_cnt     (wr_cnt),
      .rd_cnt     (rd_cnt),
      .slverr_cnt (slverr_cnt)
`ifdef APB_MON_LATENCY_EN
      ,
      .max_wait   (max_wait)
`endif
   );

   typedef struct {
      logic [1:0]  psel;
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  strb;
      logic [31:0] wd;
      logic        en;
      logic        rdy;
      logic        serr;
      logic        clr;
      logic        ev;
      logic [2:0]  code;
      logic [6:0]  flags;
      logic        done;
      logic        bsy;
      int          wc;
      int          rc;
      int          sc;
   } vec_t;

   vec_t vq[$];

   task automatic add(
      input logic [1:0] psel, input logic [31:0] addr, input logic wr,
      input logic [3:0] strb, input logic [31:0] wd, input logic en,
      input logic rdy, input logic serr, input logic clr,
      input logic ev, input logic [2:0] code, input logic [6:0] flags,
      input logic done, input logic bsy, input int wc, input int rc,
      input int sc);
      vec_t v;
      v = '{psel, addr, wr, strb, wd, en, rdy, serr, clr,
            ev, code, flags, done, bsy, wc, rc, sc};
      vq.push_back(v);
   endtask

   task automatic drive(
      input logic [1:0] psel, input logic [31:0] addr, input logic wr,
      input logic [3:0] strb, input logic [31:0] wd, input logic en,
      input logic rdy, input logic serr, input logic clr);
      PSEL      = psel;
      PADDR     = addr;
      PWRITE    = wr;
      PSTRB     = strb;
      PWDATA    = wd;
      PENABLE   = en;
      PREADY    = rdy;
      PSLVERR   = serr;
      err_clear = clr;
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string name, input int row,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic chk_all(
      input int row, input logic ev, input logic [2:0] code,
      input logic [6:0] flags, input logic done, input logic bsy,
      input int wc, input int rc, input int sc);
      chk("err_valid",  row, 32'(err_valid),  32'(ev));
      chk("err_code",   row, 32'(err_code),   32'(code));
      chk("err_flags",  row, 32'(err_flags),  32'(flags));
      chk("xfer_done",  row, 32'(xfer_done),  32'(done));
      chk("busy",       row, 32'(busy),       32'(bsy));
      chk("wr_cnt",     row, 32'(wr_cnt),     32'(wc));
      chk("rd_cnt",     row, 32'(rd_cnt),     32'(rc));
      chk("slverr_cnt", row, 32'(slverr_cnt), 32'(sc));
   endtask

   initial begin
      PRDATA  = 32'hDEAD_BEEF;
      PRESETn = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      chk_all(1000, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef APB_MON_LATENCY_EN
      chk("max_wait_rst", 1000, 32'(max_wait), 0);
`endif
      PRESETn = 1'b1;

      // zero-wait write
      add(0, 0,     0, 0,   0,           0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0);
      add(1, 'h10,  1, 'hF, 'hA5A50000,  0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0);
      add(1, 'h10,  1, 'hF, 'hA5A50000,  1, 1, 0, 0, 0, 0, 0,     1, 0, 1, 0, 0);
      add(0, 0,     0, 0,   0,           0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0);
      // read, 3 waits, slave error
      add(1, 'h20,  0, 0,   0,           0, 0, 0, 0, 0, 0, 0,     0, 1, 1, 0, 0);
      add(1, 'h20,  0, 0,   0,           1, 0, 0, 0, 0, 0, 0,     0, 1, 1, 0, 0);
      add(1, 'h20,  0, 0,   0,           1, 0, 0, 0, 0, 0, 0,     0, 1, 1, 0, 0);
      add(1, 'h20,  0, 0,   0,           1, 0, 0, 0, 0, 0, 0,     0, 1, 1, 0, 0);
      add(1, 'h20,  0, 0,   0,           1, 1, 1, 0, 0, 0, 0,     1, 0, 1, 1, 1);
      add(0, 0,     0, 0,   0,           0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 1, 1);
      // back-to-back write then read
      add(1, 'h30,  1, 'hF, 'h11,        0, 0, 0, 0, 0, 0, 0,     0, 1, 1, 1, 1);
      add(1, 'h30,  1, 'hF, 'h11,        1, 1, 0, 0, 0, 0, 0,     1, 0, 2, 1, 1);
      add(1, 'h34,  0, 0,   0,           0, 0, 0, 0, 0, 0, 0,     0, 1, 2, 1, 1);
      add(1, 'h34,  0, 0,   0,           1, 1, 0, 0, 0, 0, 0,     1, 0, 2, 2, 1);
      // address change during wait
      add(1, 'h10,  1, 'hF, 5,           0, 0, 0, 0, 0, 0, 0,     0, 1, 2, 2, 1);
      add(1, 'h10,  1, 'hF, 5,           1, 0, 0, 0, 0, 0, 0,     0, 1, 2, 2, 1);
      add(1, 'h14,  1, 'hF, 5,           1, 0, 0, 0, 1, 3, 'h08,  0, 1, 2, 2, 1);
      add(1, 'h10,  1, 'hF, 5,           1, 1, 0, 0, 0, 3, 'h08,  1, 0, 3, 2, 1);
      add(0, 0,     0, 0,   0,           0, 0, 0, 1, 0, 3, 0,     0, 0, 3, 2, 1);
      // two selects plus enable while idle
      add(3, 0,     0, 0,   0,           1, 0, 0, 0, 1, 0, 'h03,  0, 0, 3, 2, 1);
      add(0, 0,     0, 0,   0,           0, 0, 0, 1, 0, 0, 0,     0, 0, 3, 2, 1);
      // strobes on a read
      add(1, 'h40,  0, 1,   0,           0, 0, 0, 0, 1, 6, 'h40,  0, 1, 3, 2, 1);
      add(1, 'h40,  0, 1,   0,           1, 1, 0, 0, 0, 6, 'h40,  1, 0, 3, 3, 1);
      add(0, 0,     0, 0,   0,           0, 0, 0, 1, 0, 6, 0,     0, 0, 3, 3, 1);
      // setup without enable
      add(1, 'h50,  1, 'hF, 0,           0, 0, 0, 0, 0, 6, 0,     0, 1, 3, 3, 1);
      add(0, 0,     0, 0,   0,           0, 0, 0, 0, 1, 2, 'h04,  0, 0, 3, 3, 1);
      // select drop during wait
      add(1, 'h60,  1, 'hF, 0,           0, 0, 0, 0, 0, 2, 'h04,  0, 1, 3, 3, 1);
      add(1, 'h60,  1, 'hF, 0,           1, 0, 0, 0, 0, 2, 'h04,  0, 1, 3, 3, 1);
      add(0, 0,     0, 0,   0,           0, 0, 0, 0, 1, 5, 'h24,  0, 0, 3, 3, 1);
      add(0, 0,     0, 0,   0,           0, 0, 0, 1, 0, 5, 0,     0, 0, 3, 3, 1);
      // multi-select setup with clear: set wins
      add(3, 'h70,  1, 'hF, 0,           0, 0, 0, 1, 1, 0, 'h01,  0, 1, 3, 3, 1);
      add(3, 'h70,  1, 'hF, 0,           1, 1, 0, 0, 1, 0, 'h01,  1, 0, 4, 3, 1);
      add(0, 0,     0, 0,   0,           0, 0, 0, 1, 0, 0, 0,     0, 0, 4, 3, 1);
      // setup followed by a new setup
      add(1, 'h80,  1, 'hF, 0,           0, 0, 0, 0, 0, 0, 0,     0, 1, 4, 3, 1);
      add(1, 'h84,  1, 'hF, 0,           0, 0, 0, 0, 1, 2, 'h04,  0, 1, 4, 3, 1);
      add(1, 'h84,  1, 'hF, 0,           1, 1, 0, 0, 0, 2, 'h04,  1, 0, 5, 3, 1);
      add(0, 0,     0, 0,   0,           0, 0, 0, 1, 0, 2, 0,     0, 0, 5, 3, 1);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].psel, vq[i].addr, vq[i].wr, vq[i].strb, vq[i].wd,
               vq[i].en, vq[i].rdy, vq[i].serr, vq[i].clr);
         step();
         chk_all(i, vq[i].ev, vq[i].code, vq[i].flags, vq[i].done,
                 vq[i].bsy, vq[i].wc, vq[i].rc, vq[i].sc);
      end
`ifdef APB_MON_LATENCY_EN
      chk("max_wait_3", 2000, 32'(max_wait), 3);
`endif

      // timeout: PREADY never rises
      drive(1, 'h90, 1, 'hF, 0, 0, 0, 0, 0);
      step();
      chk("to_busy", 3000, 32'(busy), 1);
      for (int i = 1; i <= TO; i++) begin
         drive(1, 'h90, 1, 'hF, 0, 1, 0, 0, 0);
         step();
         if (i < TO) begin
            chk("to_ev_early", 3000 + i, 32'(err_valid), 0);
            chk("to_busy_early", 3000 + i, 32'(busy), 1);
         end else begin
            chk_all(3000 + i, 1, 4, 'h10, 0, 0, 5, 3, 1);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk_all(3100, 0, 4, 'h10, 0, 0, 5, 3, 1);
`ifdef APB_MON_LATENCY_EN
      chk("max_wait_to", 3100, 32'(max_wait), 3);
`endif

      // reset in the middle of a waited transfer
      drive(1, 'hA0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 'hA0, 0, 0, 0, 1, 0, 0, 0);
      step();
      step();
      chk("rst_pre_busy", 4000, 32'(busy), 1);
      PRESETn = 1'b0;
      step();
      chk_all(4001, 0, 0, 0, 0, 0, 0, 0, 0);
      PRESETn = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk_all(4002, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef APB_MON_LATENCY_EN
      chk("max_wait_rst2", 4002, 32'(max_wait), 0);
`endif

      // write counter saturates at all-ones
      for (int i = 1; i <= 17; i++) begin
         drive(1, 'hB0, 1, 'hF, i, 0, 0, 0, 0);
         step();
         drive(1, 'hB0, 1, 'hF, i, 1, 1, 0, 0);
         step();
         if (i == 15 || i == 17) begin
            chk_all(5000 + i, 0, 0, 0, 1, 0, 15, 0, 0);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("sat_hold", 5100, 32'(wr_cnt), 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
